// File: rtl/serial_parity_rx.sv
// Serial-parity link receiver: start, DATA_W data bits LSB first, parity, stop.
// Define PARITY_RX_FIFO_EN for a 2-entry output FIFO instead of a single holding register.
module serial_parity_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned WORD_W = DATA_W + 2;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              par_acc;
    logic              frame_done;
    logic [WORD_W-1:0] new_word;

    always_comb begin
        shift_next             = shift_reg >> 1;
        shift_next[DATA_W-1]   = bit_in;
    end

    // After the parity strobe par_acc is nonzero exactly when parity mismatched
    assign frame_done = bit_valid && (state == S_STOP);
    assign new_word   = {par_acc, ~bit_in, shift_reg};
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_acc   <= 1'b0;
        end else if (bit_valid) begin
            case (state)
                S_IDLE: begin
                    if (!bit_in) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        par_acc <= ODD_PARITY;
                    end
                end
                S_DATA: begin
                    shift_reg <= shift_next;
                    par_acc   <= par_acc ^ bit_in;
                    if (bit_cnt == LAST_BIT) begin
                        state <= S_PARITY;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    par_acc <= par_acc ^ bit_in;
                    state   <= S_STOP;
                end
                S_STOP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PARITY_RX_FIFO_EN
    logic [WORD_W-1:0] spare_word;
    logic              spare_valid;
    logic              pop;

    assign pop = out_valid && out_ready;

    // Head entry lives directly in the output registers; spare_word is the second slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            spare_word  <= '0;
            spare_valid <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (pop) begin
                if (spare_valid) begin
                    {parity_err, frame_err, out_data} <= spare_word;
                    spare_valid <= frame_done;
                    if (frame_done) begin
                        spare_word <= new_word;
                    end
                end else if (frame_done) begin
                    {parity_err, frame_err, out_data} <= new_word;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (frame_done) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    {parity_err, frame_err, out_data} <= new_word;
                end else if (!spare_valid) begin
                    spare_valid <= 1'b1;
                    spare_word  <= new_word;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                {parity_err, frame_err, out_data} <= new_word;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (frame_done) begin
                    overrun <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx: vector table plus hand sequences,
// with received words scored against an expectation queue.
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b1;
    logic       bit_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic       odd_bit = 1'b1;
    logic       odd_valid = 1'b0;
    logic [7:0] odd_data;
    logic       odd_out_valid;
    logic       odd_ready = 1'b0;
    logic       odd_perr;
    logic       odd_ferr;
    logic       odd_overrun;
    logic       odd_busy;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_in(odd_bit), .bit_valid(odd_valid),
        .out_data(odd_data), .out_valid(odd_out_valid), .out_ready(odd_ready),
        .parity_err(odd_perr), .frame_err(odd_ferr), .overrun(odd_overrun), .busy(odd_busy)
    );

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic        stop;
        int unsigned gap_max;
        logic [7:0]  exp_data;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int valid_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) ovr_cnt++;
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("word_data", out_data, mon_e.data);
                    chk("word_parity_err", parity_err, mon_e.perr);
                    chk("word_frame_err", frame_err, mon_e.ferr);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        sb.push_back(e);
    endtask

    task automatic send_bit(input bit sel, input logic b, input int unsigned gap);
        repeat (gap) begin
            @(posedge clk); #1;
            bit_valid = 1'b0;
            odd_valid = 1'b0;
        end
        @(posedge clk); #1;
        if (sel) begin
            odd_bit   = b;
            odd_valid = 1'b1;
            bit_valid = 1'b0;
        end else begin
            bit_in    = b;
            bit_valid = 1'b1;
            odd_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                              input logic stop, input int unsigned gap_max);
        send_bit(sel, 1'b0, $urandom_range(gap_max, 0));
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], $urandom_range(gap_max, 0));
        send_bit(sel, par, $urandom_range(gap_max, 0));
        send_bit(sel, stop, $urandom_range(gap_max, 0));
        @(posedge clk); #1;
        bit_valid = 1'b0;
        odd_valid = 1'b0;
        bit_in    = 1'b1;
        odd_bit   = 1'b1;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue", sb.size(), 0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 5, 8'h80, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 5, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 3, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h5A, 1'b0, 1'b1, 5, 8'h5A, 1'b0, 1'b0};
        vecs[7] = '{8'h01, 1'b0, 1'b1, 2, 8'h01, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A5 frame: valid one cycle after the stop strobe, a single beat
        valid_cycles = 0;
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 0);
        chk("latency_out_valid", out_valid, 1);
        chk("busy_after_stop", busy, 0);
        wait_drain(20);
        repeat (3) @(posedge clk);
        #1;
        chk("one_valid_beat", valid_cycles, 1);

        for (int i = 0; i < 8; i++) begin
            push_exp(vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
            send_frame(1'b0, vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].gap_max);
            wait_drain(40);
        end

        // Odd-parity instance
        send_frame(1'b1, 8'h01, 1'b0, 1'b1, 0);
        chk("odd_valid", odd_out_valid, 1);
        chk("odd_data", odd_data, 8'h01);
        chk("odd_parity_err", odd_perr, 0);
        chk("odd_frame_err", odd_ferr, 0);
        odd_ready = 1'b1;
        @(posedge clk); #1;
        odd_ready = 1'b0;
        chk("odd_accepted", odd_out_valid, 0);
        send_frame(1'b1, 8'h01, 1'b0, 1'b0, 1);
        chk("odd_stop0_data", odd_data, 8'h01);
        chk("odd_stop0_parity_err", odd_perr, 0);
        chk("odd_stop0_frame_err", odd_ferr, 1);
        odd_ready = 1'b1;
        @(posedge clk); #1;
        odd_ready = 1'b0;
        send_frame(1'b1, 8'h01, 1'b1, 1'b1, 0);
        chk("odd_bad_parity_err", odd_perr, 1);

        // Overrun with a stalled consumer
        out_ready = 1'b0;
        ovr_cnt = 0;
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(1'b0, 8'h11, 1'b0, 1'b1, 0);
`ifdef PARITY_RX_FIFO_EN
        push_exp(8'h22, 1'b0, 1'b0);
        send_frame(1'b0, 8'h22, 1'b0, 1'b1, 0);
        chk("no_overrun_second", ovr_cnt, 0);
        send_frame(1'b0, 8'h33, 1'b0, 1'b1, 0);
`else
        send_frame(1'b0, 8'h22, 1'b0, 1'b1, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("overrun_pulses", ovr_cnt, 1);
        chk("held_valid", out_valid, 1);
        chk("held_data", out_data, 8'h11);
        out_ready = 1'b1;
        wait_drain(20);
        repeat (3) @(posedge clk);
        #1;
        chk("empty_after_drain", out_valid, 0);

        // Reset during the 4th data bit with a word held at the output
        out_ready = 1'b0;
        send_frame(1'b0, 8'h77, 1'b0, 1'b1, 0);
        chk("held_before_reset", out_valid, 1);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b0, 1'b1, 0);
        @(posedge clk); #1;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        chk("busy_mid_frame", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        bit_valid = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_parity_err", parity_err, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 2);
        wait_drain(40);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
